single_tone_estimator: RTL

//   Measures amplitude and phase of a DC-downconverted single-tone calibration burst and

---
 rtl/single_tone_estimator.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/single_tone_estimator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : single_tone_estimator
// Purpose  : Averages 2^LOG2_N I/Q tone samples and runs a vectoring CORDIC to
//            report the tone amplitude and phase (fix12_8 radians).
// Revision : 1.0  initial release
// ============================================================================
module single_tone_estimator #(
    parameter int LOG2_N = 4,
    parameter int ITER   = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic signed [11:0] tone_i,
    input  logic signed [11:0] tone_q,
    input  logic               tone_valid,
    output logic signed [11:0] channel_amplitude,
    output logic signed [11:0] channel_phase,
    output logic               channel_data_valid,
    output logic               busy
);

    localparam int DW    = 16;
    localparam int ACC_W = 12 + LOG2_N;
    // Two fractional guard bits keep the truncating CORDIC shifts from biasing the magnitude.
    localparam int GUARD = 2;
    localparam int KW    = $clog2(ITER + 1);

    localparam logic signed [DW-1:0] PI_Z     = 16'sd12868;
    localparam logic signed [DW:0]   PH_MAX   = 17'sd804;
    localparam logic signed [DW:0]   PH_MIN   = -17'sd804;
    localparam logic        [31:0]   INV_K    = 32'd622;
    localparam logic        [31:0]   AMP_RND  = 32'd1 << (9 + GUARD);
    localparam logic        [31:0]   AMP_MAX  = 32'd2047;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCUM  = 3'd1,
        S_MEAN   = 3'd2,
        S_PREROT = 3'd3,
        S_ITER   = 3'd4,
        S_SCALE  = 3'd5,
        S_OUT    = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t state, state_nxt;

    logic signed [ACC_W-1:0] acc_i, acc_q;
    logic        [LOG2_N-1:0] cnt;
    logic signed [DW-1:0]    x, y, z;
    logic        [KW-1:0]    k;
    logic                    zero_vec;
    logic        [11:0]      amp_s;
    logic signed [11:0]      ph_s;

    logic signed [ACC_W-1:0] mean_i_full, mean_q_full;
    logic signed [DW-1:0]    mean_i_ext, mean_q_ext;
    logic signed [DW-1:0]    x_sh, y_sh, atan_k;
    logic        [DW-1:0]    x_mag;
    logic        [31:0]      amp_prod, amp_q;
    logic signed [DW:0]      z_rnd;

    function automatic logic signed [DW-1:0] atan_rom(input logic [KW-1:0] idx);
        case (idx)
            KW'(0):  atan_rom = 16'sd3217;
            KW'(1):  atan_rom = 16'sd1899;
            KW'(2):  atan_rom = 16'sd1003;
            KW'(3):  atan_rom = 16'sd509;
            KW'(4):  atan_rom = 16'sd256;
            KW'(5):  atan_rom = 16'sd128;
            KW'(6):  atan_rom = 16'sd64;
            KW'(7):  atan_rom = 16'sd32;
            KW'(8):  atan_rom = 16'sd16;
            KW'(9):  atan_rom = 16'sd8;
            KW'(10): atan_rom = 16'sd4;
            KW'(11): atan_rom = 16'sd2;
            KW'(12): atan_rom = 16'sd1;
            default: atan_rom = 16'sd0;
        endcase
    endfunction

    assign mean_i_full = acc_i >>> LOG2_N;
    assign mean_q_full = acc_q >>> LOG2_N;
    assign mean_i_ext  = DW'(mean_i_full) <<< GUARD;
    assign mean_q_ext  = DW'(mean_q_full) <<< GUARD;

    assign x_sh   = x >>> k;
    assign y_sh   = y >>> k;
    assign atan_k = atan_rom(k);

    assign x_mag    = x[DW-1] ? '0 : x;
    assign amp_prod = 32'(x_mag) * INV_K + AMP_RND;
    assign amp_q    = amp_prod >> (10 + GUARD);
    // z is fix16_12; dropping 4 bits with +8 rounds to fix12_8.
    assign z_rnd    = ($signed({z[DW-1], z}) + 17'sd8) >>> 4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_ACCUM;
            S_ACCUM:  if (tone_valid && (cnt == '1)) state_nxt = S_MEAN;
            S_MEAN:   state_nxt = S_PREROT;
            S_PREROT: state_nxt = S_ITER;
            S_ITER:   if (k == KW'(ITER - 1)) state_nxt = S_SCALE;
            S_SCALE:  state_nxt = S_OUT;
            S_OUT:    state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_i              <= '0;
            acc_q              <= '0;
            cnt                <= '0;
            x                  <= '0;
            y                  <= '0;
            z                  <= '0;
            k                  <= '0;
            zero_vec           <= 1'b0;
            amp_s              <= '0;
            ph_s               <= '0;
            channel_amplitude  <= '0;
            channel_phase      <= '0;
            channel_data_valid <= 1'b0;
            busy               <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc_i <= '0;
                        acc_q <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (tone_valid) begin
                        acc_i <= acc_i + ACC_W'(tone_i);
                        acc_q <= acc_q + ACC_W'(tone_q);
                        cnt   <= cnt + LOG2_N'(1);
                    end
                end
                S_MEAN: begin
                    x        <= mean_i_ext;
                    y        <= mean_q_ext;
                    zero_vec <= (mean_i_full == '0) && (mean_q_full == '0);
                end
                S_PREROT: begin
                    // Left half-plane: rotate by pi so CORDIC only sees |angle| <= pi/2.
                    if (x[DW-1]) begin
                        x <= -x;
                        y <= -y;
                        z <= y[DW-1] ? -PI_Z : PI_Z;
                    end else begin
                        z <= '0;
                    end
                    k <= '0;
                end
                S_ITER: begin
                    if (y[DW-1]) begin
                        x <= x - y_sh;
                        y <= y + x_sh;
                        z <= z - atan_k;
                    end else begin
                        x <= x + y_sh;
                        y <= y - x_sh;
                        z <= z + atan_k;
                    end
                    k <= k + KW'(1);
                end
                S_SCALE: begin
                    amp_s <= (amp_q > AMP_MAX) ? AMP_MAX[11:0] : amp_q[11:0];
                    if (z_rnd > PH_MAX)      ph_s <= PH_MAX[11:0];
                    else if (z_rnd < PH_MIN) ph_s <= PH_MIN[11:0];
                    else                     ph_s <= z_rnd[11:0];
                end
                S_OUT: begin
                    channel_amplitude  <= zero_vec ? 12'sd0 : $signed(amp_s);
                    channel_phase      <= zero_vec ? 12'sd0 : ph_s;
                    channel_data_valid <= 1'b1;
                end
                S_DONE: begin
                    channel_data_valid <= 1'b0;
                    busy               <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
